// File: rtl/uart_pgm_loader.sv
// uart_pgm_loader: framed UART program loader.
// Frame = SYNC, LEN_LO, LEN_HI (word count N), N*BPW data bytes, XOR checksum.
// Assembled words are written to sequential instruction-memory addresses from 0.
module uart_pgm_loader #(
    parameter int          DATA_W         = 32,
    parameter int          ADDR_W         = 10,
    parameter int          BIG_ENDIAN     = 0,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic              pgm_mode,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);

    localparam int BPW  = DATA_W / 8;
    localparam int BI_W = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_DONE, S_ERROR
    } state_t;

    state_t            state;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [7:0]        csum;
    logic [BI_W-1:0]   bidx;
    logic [DATA_W-1:0] word_buf;
    logic [31:0]       tmo_cnt;

    logic [BI_W-1:0]   lane;
    logic [DATA_W-1:0] word_nxt;
    logic              last_byte;
    logic              last_word;
    logic              len_ovf;
    logic              start_frame;

    // Busy covers every state in which a frame is still being received.
    assign busy = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                  (state == S_DATA)   || (state == S_CHK);

    // Byte placement, end-of-word/frame detection and restart decode.
    always_comb begin
        lane = (BIG_ENDIAN != 0) ? (BI_W'(BPW - 1) - bidx) : bidx;
        word_nxt = word_buf;
        for (int i = 0; i < BPW; i++) begin
            if (lane == BI_W'(i)) word_nxt[i*8 +: 8] = rx_data;
        end
        last_byte   = (bidx == BI_W'(BPW - 1));
        last_word   = ((32'(word_count) + 32'd1) == {16'd0, len});
        // N is only legal up to the full memory capacity
        len_ovf     = (64'({rx_data, len_lo}) > (64'd1 << ADDR_W));
        start_frame = rx_data_ready && (rx_data == SYNC_BYTE) &&
                      ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    end

    // Frame FSM: pgm_mode low wins over everything except reset; a byte
    // arriving clears the inter-byte timer, otherwise the timer advances.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state      <= S_IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'd0;
            word_count <= '0;
            len_lo     <= '0;
            len        <= '0;
            csum       <= '0;
            bidx       <= '0;
            word_buf   <= '0;
            tmo_cnt    <= '0;
        end else begin
            mem_we <= 1'b0;
            if (!pgm_mode) begin
                state <= S_IDLE;
            end else if (start_frame) begin
                state      <= S_LEN_LO;
                done       <= 1'b0;
                err        <= 1'b0;
                err_code   <= 2'd0;
                word_count <= '0;
                csum       <= '0;
                bidx       <= '0;
                word_buf   <= '0;
                tmo_cnt    <= '0;
            end else if (busy && rx_data_ready) begin
                tmo_cnt <= '0;
                case (state)
                    S_LEN_LO: begin
                        len_lo <= rx_data;
                        state  <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        len <= {rx_data, len_lo};
                        if (len_ovf) begin
                            state    <= S_ERROR;
                            err      <= 1'b1;
                            err_code <= 2'd2;
                        end else if ({rx_data, len_lo} == 16'd0) begin
                            state <= S_CHK;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        csum <= csum ^ rx_data;
                        if (last_byte) begin
                            mem_we     <= 1'b1;
                            mem_addr   <= word_count[ADDR_W-1:0];
                            mem_wdata  <= word_nxt;
                            word_count <= word_count + 1'b1;
                            bidx       <= '0;
                            if (last_word) state <= S_CHK;
                        end else begin
                            word_buf <= word_nxt;
                            bidx     <= bidx + 1'b1;
                        end
                    end
                    S_CHK: begin
                        if (rx_data == csum) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= S_ERROR;
                            err      <= 1'b1;
                            err_code <= 2'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (busy && (TIMEOUT_CYCLES != 0)) begin
                if (tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                    state    <= S_ERROR;
                    err      <= 1'b1;
                    err_code <= 2'd3;
                end else begin
                    tmo_cnt <= tmo_cnt + 32'd1;
                end
            end
        end
    end

endmodule
